ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 25 ++
 rtl/ram_arbiter_pick.sv | 28 ++
 rtl/ram_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the CPU / front-panel RAM arbiter.
package ram_arb_pkg;

   localparam int unsigned ADDR_W            = 8;
   localparam int unsigned DATA_W            = 8;
   localparam int unsigned CNT_W             = 4;
   localparam int unsigned ACCESS_CYCLES_DEF = 2;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_LD  = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      DONE   = 2'd3
   } state_e;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } ram_req_t;

endpackage

// File: rtl/ram_arbiter_pick.sv
// Grant decision for the RAM arbiter. ARB_RR_EN selects round-robin on a tie;
// otherwise the loader has fixed priority over the CPU.
module arb_pick
   import ram_arb_pkg::*;
(
   input  logic cpu_req,
   input  logic ld_req,
   input  logic last_gnt,
   output logic winner_c
);

`ifdef ARB_RR_EN
   always_comb begin
      winner_c = REQ_CPU;
      if (cpu_req && ld_req) winner_c = ~last_gnt;
      else if (ld_req)       winner_c = REQ_LD;
   end
`else
   logic unused_last_gnt;
   assign unused_last_gnt = last_gnt ^ cpu_req;

   always_comb begin
      winner_c = REQ_CPU;
      if (ld_req) winner_c = REQ_LD;
   end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester RAM arbiter with a SETUP / STROBE / DONE access sequence.
// Optional macro ARB_RR_EN enables round-robin tie resolution.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_ack,
   output logic [DATA_W-1:0] ld_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_dout,
   output logic              ram_oe,
   input  logic [DATA_W-1:0] ram_din,
   output logic              ram_w,
   output logic              ram_r,
   output logic              busy,
   output logic              gnt
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic              last_gnt_q, last_gnt_d;
   logic              gnt_q, gnt_d;
   logic              busy_q, busy_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_dout_q, ram_dout_d;
   logic              ram_oe_q, ram_oe_d;
   logic              ram_w_q, ram_w_d;
   logic              ram_r_q, ram_r_d;
   logic              cpu_ack_q, cpu_ack_d;
   logic              ld_ack_q, ld_ack_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;

   logic     winner_c;
   ram_req_t sel_c;

   arb_pick u_pick (
      .cpu_req  (cpu_req),
      .ld_req   (ld_req),
      .last_gnt (last_gnt_q),
      .winner_c (winner_c)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      last_gnt_d  = last_gnt_q;
      gnt_d       = gnt_q;
      ram_addr_d  = ram_addr_q;
      ram_dout_d  = ram_dout_q;
      ram_oe_d    = ram_oe_q;
      ram_w_d     = ram_w_q;
      ram_r_d     = ram_r_q;
      cpu_ack_d   = 1'b0;
      ld_ack_d    = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      ld_rdata_d  = ld_rdata_q;
      sel_c       = (winner_c == REQ_LD) ? ram_req_t'{ld_we, ld_addr, ld_wdata}
                                         : ram_req_t'{cpu_we, cpu_addr, cpu_wdata};

      case (state_q)
         IDLE: begin
            if (cpu_req || ld_req) begin
               gnt_d      = winner_c;
               last_gnt_d = winner_c;
               we_d       = sel_c.we;
               ram_addr_d = sel_c.addr;
               ram_dout_d = sel_c.wdata;
               ram_oe_d   = sel_c.we;
               state_d    = SETUP;
            end
         end
         SETUP: begin
            ram_w_d = ~we_q;
            ram_r_d = we_q;
            cnt_d   = CNT_W'(ACCESS_CYCLES - 1);
            state_d = STROBE;
         end
         STROBE: begin
            if (cnt_q == '0) begin
               // Last strobe cycle: sample read data, raise strobes, ack the owner.
               ram_w_d = 1'b1;
               ram_r_d = 1'b1;
               if (!we_q) begin
                  if (gnt_q == REQ_LD) ld_rdata_d  = ram_din;
                  else                 cpu_rdata_d = ram_din;
               end
               if (gnt_q == REQ_LD) ld_ack_d  = 1'b1;
               else                 cpu_ack_d = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = CNT_W'(cnt_q - 1'b1);
            end
         end
         DONE: begin
            ram_oe_d = 1'b0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         last_gnt_q  <= REQ_CPU;
         gnt_q       <= 1'b0;
         busy_q      <= 1'b0;
         ram_addr_q  <= '0;
         ram_dout_q  <= '0;
         ram_oe_q    <= 1'b0;
         ram_w_q     <= 1'b1;
         ram_r_q     <= 1'b1;
         cpu_ack_q   <= 1'b0;
         ld_ack_q    <= 1'b0;
         cpu_rdata_q <= '0;
         ld_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         last_gnt_q  <= last_gnt_d;
         gnt_q       <= gnt_d;
         busy_q      <= busy_d;
         ram_addr_q  <= ram_addr_d;
         ram_dout_q  <= ram_dout_d;
         ram_oe_q    <= ram_oe_d;
         ram_w_q     <= ram_w_d;
         ram_r_q     <= ram_r_d;
         cpu_ack_q   <= cpu_ack_d;
         ld_ack_q    <= ld_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         ld_rdata_q  <= ld_rdata_d;
      end
   end

   assign cpu_ack   = cpu_ack_q;
   assign ld_ack    = ld_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign ld_rdata  = ld_rdata_q;
   assign ram_addr  = ram_addr_q;
   assign ram_dout  = ram_dout_q;
   assign ram_oe    = ram_oe_q;
   assign ram_w     = ram_w_q;
   assign ram_r     = ram_r_q;
   assign busy      = busy_q;
   assign gnt       = gnt_q;

endmodule
